// File: rtl/reg_file_serializer_if.sv
// Output stream interface for reg_file_serializer.
//   out_valid : chunk on out_data is valid (master -> slave)
//   out_ready : downstream accepts the current chunk (slave -> master)
//   out_data  : current OUT_W-bit chunk (master -> slave)
//   out_last  : current chunk is the final beat (master -> slave)
interface reg_file_serializer_if #(
  parameter int unsigned OUT_W = 8
);
  logic             out_valid;
  logic             out_ready;
  logic [OUT_W-1:0] out_data;
  logic             out_last;

  modport master (
    output out_valid,
    output out_data,
    output out_last,
    input  out_ready
  );

  modport slave (
    input  out_valid,
    input  out_data,
    input  out_last,
    output out_ready
  );
endinterface

// File: rtl/reg_file_serializer.sv
// Snapshots one ED25519 register-file entry on request and streams it out
// least-significant chunk first over a valid/ready interface.
//   clk       : clock
//   rst       : asynchronous, active-low reset
//   i_start   : one-cycle request, sampled only when idle
//   i_sel     : register select (0 A1, 1 A2, 2 A3, 3 B1, 4 B2, 5 C1, 6 C2, 7 invalid)
//   i_reg_*   : register file contents (A3/B2 are 256 bits, the rest 512)
//   out_if    : output stream (valid/ready/data/last)
//   o_busy    : high while a transfer (or its done cycle) is in progress
//   o_done    : one-cycle pulse after the last beat is accepted
//   o_err     : one-cycle pulse after a start with an invalid select
module reg_file_serializer #(
  parameter int unsigned OUT_W = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_start,
  input  logic [2:0]            i_sel,
  input  logic [511:0]          i_reg_a1,
  input  logic [511:0]          i_reg_a2,
  input  logic [255:0]          i_reg_a3,
  input  logic [511:0]          i_reg_b1,
  input  logic [255:0]          i_reg_b2,
  input  logic [511:0]          i_reg_c1,
  input  logic [511:0]          i_reg_c2,
  reg_file_serializer_if.master out_if,
  output logic                  o_busy,
  output logic                  o_done,
  output logic                  o_err
);

  localparam int unsigned BeatsFull = 512 / OUT_W;
  localparam int unsigned BeatsHalf = 256 / OUT_W;
  localparam int unsigned CntW      = $clog2(BeatsFull);

  typedef enum logic [1:0] {StIdle, StSend, StDone} state_e;

  state_e          r_state;
  logic [511:0]    r_shift;
  logic [CntW-1:0] r_cnt;
  // Index of the final beat (len-1); keeps the width at CntW even for OUT_W=64.
  logic [CntW-1:0] r_len_m1;
  logic            r_valid;
  logic            r_done;
  logic            r_err;

  logic [511:0]    w_src;
  logic            w_half;
  logic            w_last;

  always_comb begin
    w_src  = '0;
    w_half = 1'b0;
    case (i_sel)
      3'b000:  w_src = i_reg_a1;
      3'b001:  w_src = i_reg_a2;
      3'b010:  begin w_src = 512'(i_reg_a3); w_half = 1'b1; end
      3'b011:  w_src = i_reg_b1;
      3'b100:  begin w_src = 512'(i_reg_b2); w_half = 1'b1; end
      3'b101:  w_src = i_reg_c1;
      3'b110:  w_src = i_reg_c2;
      default: w_src = '0;
    endcase
  end

  assign w_last = r_valid && (r_cnt == r_len_m1);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state  <= StIdle;
      r_shift  <= '0;
      r_cnt    <= '0;
      r_len_m1 <= '0;
      r_valid  <= 1'b0;
      r_done   <= 1'b0;
      r_err    <= 1'b0;
    end else begin
      r_done <= 1'b0;
      r_err  <= 1'b0;
      case (r_state)
        StIdle: begin
          if (i_start) begin
            if (i_sel == 3'b111) begin
              r_err <= 1'b1;
            end else begin
              r_shift  <= w_src;
              r_cnt    <= '0;
              r_len_m1 <= w_half ? CntW'(BeatsHalf - 1) : CntW'(BeatsFull - 1);
              r_valid  <= 1'b1;
              r_state  <= StSend;
            end
          end
        end
        StSend: begin
          if (out_if.out_ready) begin
            r_shift <= r_shift >> OUT_W;
            if (w_last) begin
              // Counter is not advanced past len-1, so it never wraps.
              r_cnt   <= '0;
              r_valid <= 1'b0;
              r_done  <= 1'b1;
              r_state <= StDone;
            end else begin
              r_cnt <= r_cnt + 1'b1;
            end
          end
        end
        StDone: begin
          r_state <= StIdle;
        end
        default: begin
          r_state <= StIdle;
          r_valid <= 1'b0;
        end
      endcase
    end
  end

  assign out_if.out_valid = r_valid;
  assign out_if.out_data  = r_shift[OUT_W-1:0];
  assign out_if.out_last  = w_last;
  assign o_busy           = (r_state != StIdle);
  assign o_done           = r_done;
  assign o_err            = r_err;

endmodule

// File: tb/tb_reg_file_serializer.sv
module tb_reg_file_serializer;

  logic         clk;
  logic         rst;
  logic         i_start;
  logic [2:0]   i_sel;
  logic [511:0] regs [0:6];
  logic         o_busy;
  logic         o_done;
  logic         o_err;

  int errors;
  int checks;
  int done_cnt;
  int err_cnt;

  reg_file_serializer_if #(.OUT_W(8)) u_if ();

  reg_file_serializer #(.OUT_W(8)) u_dut (
    .clk      (clk),
    .rst      (rst),
    .i_start  (i_start),
    .i_sel    (i_sel),
    .i_reg_a1 (regs[0]),
    .i_reg_a2 (regs[1]),
    .i_reg_a3 (regs[2][255:0]),
    .i_reg_b1 (regs[3]),
    .i_reg_b2 (regs[4][255:0]),
    .i_reg_c1 (regs[5]),
    .i_reg_c2 (regs[6]),
    .out_if   (u_if),
    .o_busy   (o_busy),
    .o_done   (o_done),
    .o_err    (o_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (o_done) done_cnt <= done_cnt + 1;
    if (o_err)  err_cnt  <= err_cnt + 1;
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [511:0] rand512();
    logic [511:0] v;
    for (int i = 0; i < 16; i++) v[i*32 +: 32] = $urandom;
    return v;
  endfunction

  // Reference: what the stream must carry for a given select, from current register contents.
  function automatic logic [511:0] model_src(input logic [2:0] sel);
    if (sel == 3'd2 || sel == 3'd4) return {256'b0, regs[sel][255:0]};
    return regs[sel];
  endfunction

  function automatic int model_len(input logic [2:0] sel);
    return (sel == 3'd2 || sel == 3'd4) ? 32 : 64;
  endfunction

  function automatic logic ready_pat(input int mode, input int cyc);
    if (mode == 0) return 1'b1;
    if (mode == 1) return (cyc % 3) == 0;
    return 1'($urandom % 2);
  endfunction

  // mode: 0 ready held high, 1 ready pattern 1,0,0,..., 2 random ready.
  // disturb: overwrite C1 and re-issue start mid-transfer.
  // abort_at: assert reset once this many beats were accepted (0 = never).
  task automatic stream(input logic [2:0] sel, input int mode, input bit disturb,
                        input int abort_at);
    logic [511:0] src;
    int           len;
    int           acc;
    int           cyc;
    int           d0;
    int           e0;
    bit           stalled;
    bit           aborted;
    logic [7:0]   held_d;
    logic         held_l;
    logic [7:0]   exp_b;

    src     = model_src(sel);
    len     = model_len(sel);
    acc     = 0;
    cyc     = 0;
    stalled = 0;
    aborted = 0;
    held_d  = '0;
    held_l  = 1'b0;
    @(posedge clk); #1;
    d0 = done_cnt;
    e0 = err_cnt;
    i_start = 1'b1;
    i_sel   = sel;
    @(posedge clk); #1;
    i_start = 1'b0;
    while (acc < len && cyc < 1000) begin
      u_if.out_ready = ready_pat(mode, cyc);
      if (disturb && cyc == 2) begin
        regs[5] = rand512();
        i_start = 1'b1;
        i_sel   = 3'd6;
      end else begin
        i_start = 1'b0;
      end
      @(negedge clk);
      check("valid_high", 64'(u_if.out_valid), 64'd1);
      check("busy_high", 64'(o_busy), 64'd1);
      if (stalled) begin
        check("stall_data", 64'(u_if.out_data), 64'(held_d));
        check("stall_last", 64'(u_if.out_last), 64'(held_l));
      end
      if (u_if.out_valid && u_if.out_ready) begin
        exp_b = 8'((src >> (8 * acc)) & 512'hFF);
        check("beat_data", 64'(u_if.out_data), 64'(exp_b));
        check("beat_last", 64'(u_if.out_last), 64'(acc == len - 1));
        acc++;
        stalled = 0;
        if (abort_at > 0 && acc == abort_at) begin
          #1 rst = 1'b0;
          #1;
          check("abort_valid", 64'(u_if.out_valid), 64'd0);
          check("abort_busy", 64'(o_busy), 64'd0);
          check("abort_last", 64'(u_if.out_last), 64'd0);
          check("abort_done", 64'(o_done), 64'd0);
          aborted = 1;
          break;
        end
      end else begin
        stalled = 1;
        held_d  = u_if.out_data;
        held_l  = u_if.out_last;
      end
      cyc++;
      @(posedge clk); #1;
    end
    i_start = 1'b0;
    if (aborted) begin
      @(posedge clk); #1;
      check("abort_no_done", 64'(done_cnt - d0), 64'd0);
      rst = 1'b1;
    end else begin
      check("beat_count", 64'(acc), 64'(len));
      if (mode == 0) check("full_rate", 64'(cyc), 64'(len));
      u_if.out_ready = 1'($urandom % 2);
      @(negedge clk);
      check("done_pulse", 64'(o_done), 64'd1);
      check("done_valid", 64'(u_if.out_valid), 64'd0);
      check("done_busy", 64'(o_busy), 64'd1);
      @(posedge clk); #1;
      @(negedge clk);
      check("idle_done", 64'(o_done), 64'd0);
      check("idle_busy", 64'(o_busy), 64'd0);
      check("idle_valid", 64'(u_if.out_valid), 64'd0);
      @(posedge clk); #1;
      check("one_done", 64'(done_cnt - d0), 64'd1);
      check("no_err", 64'(err_cnt - e0), 64'd0);
    end
  endtask

  initial begin
    errors         = 0;
    checks         = 0;
    done_cnt       = 0;
    err_cnt        = 0;
    rst            = 1'b0;
    i_start        = 1'b0;
    i_sel          = 3'd0;
    u_if.out_ready = 1'b0;
    for (int r = 0; r < 7; r++) regs[r] = rand512();

    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_valid", 64'(u_if.out_valid), 64'd0);
    check("rst_data", 64'(u_if.out_data), 64'd0);
    check("rst_last", 64'(u_if.out_last), 64'd0);
    check("rst_busy", 64'(o_busy), 64'd0);
    check("rst_done", 64'(o_done), 64'd0);
    check("rst_err", 64'(o_err), 64'd0);
    @(posedge clk); #1;
    rst = 1'b1;

    // A1 ascending bytes, full rate.
    for (int i = 0; i < 64; i++) regs[0][i*8 +: 8] = 8'(i);
    stream(3'd0, 0, 1'b0, 0);

    // A3 with 0xA5 ^ index pattern; junk above bit 255 must never appear.
    for (int i = 0; i < 32; i++) regs[2][i*8 +: 8] = 8'hA5 ^ 8'(i);
    stream(3'd2, 0, 1'b0, 0);

    // Backpressure on the same A1 transfer.
    stream(3'd0, 1, 1'b0, 0);

    // Snapshot of C1 with an overwrite and ignored start mid-transfer.
    regs[5] = rand512();
    stream(3'd5, 0, 1'b1, 0);

    // Invalid select.
    @(posedge clk); #1;
    begin
      int e0;
      e0      = err_cnt;
      i_start = 1'b1;
      i_sel   = 3'd7;
      @(posedge clk); #1;
      i_start = 1'b0;
      @(negedge clk);
      check("err_pulse", 64'(o_err), 64'd1);
      check("err_valid", 64'(u_if.out_valid), 64'd0);
      check("err_busy", 64'(o_busy), 64'd0);
      @(posedge clk); #1;
      @(negedge clk);
      check("err_clear", 64'(o_err), 64'd0);
      check("err_busy2", 64'(o_busy), 64'd0);
      @(posedge clk); #1;
      check("err_once", 64'(err_cnt - e0), 64'd1);
    end
    regs[4] = rand512();
    stream(3'd4, 2, 1'b0, 0);

    // Reset mid-transfer of B1, then a clean restart.
    regs[3] = rand512();
    stream(3'd3, 0, 1'b0, 20);
    regs[3] = rand512();
    stream(3'd3, 0, 1'b0, 0);

    // Random transfers.
    for (int t = 0; t < 8; t++) begin
      logic [2:0] s;
      s = 3'($urandom_range(0, 6));
      regs[s] = rand512();
      stream(s, int'($urandom_range(0, 2)), 1'b0, 0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1);
  end

endmodule

// File: doc/reg_file_serializer.md
Name: reg_file_serializer

Overview:
- Read-side companion to the ED25519 key/message/signature register file.
- On a start request, snapshots one selected register and streams it out over a valid/ready interface, least-significant chunk first.
- Handles 64-byte registers (A1, A2, B1, C1, C2) and 32-byte registers (A3, B2).
- Sits between the register file outputs and the UART/SPI transmit path.

Parameters:
- OUT_W, 8, output chunk width in bits; legal values 8/16/32/64; beats = 512/OUT_W or 256/OUT_W.

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous, active-low reset.
- start  in  1  one-cycle request to serialize register `sel`; sampled only in IDLE.
- sel  in  3  register select: 000 A1, 001 A2, 010 A3, 011 B1, 100 B2, 101 C1, 110 C2, 111 invalid.
- reg_a1, reg_a2, reg_b1, reg_c1, reg_c2  in  512 each  register file contents.
- reg_a3, reg_b2  in  256 each  register file contents.
- out_ready  in  1  downstream accepts the current chunk.
- out_valid  out  1  out_data holds a valid chunk.
- out_data  out  OUT_W  current chunk.
- out_last  out  1  current chunk is the final beat.
- busy  out  1  high while not in IDLE.
- done  out  1  one-cycle pulse after the last beat is accepted.
- err  out  1  one-cycle pulse when start is issued with sel=111.

Behaviour:
- Reset (async, rst=0):
  - State=IDLE; shift register, beat counter and length cleared.
  - All outputs 0: out_valid, out_data, out_last, busy, done, err.
- FSM states: IDLE, SEND, DONE.
- IDLE:
  - start=1 with sel≤110:
    - Capture the selected register into a 512-bit shift register; 256-bit sources are zero-extended.
    - Load beat count len = 512/OUT_W for 512-bit sources, 256/OUT_W for A3/B2.
    - Clear the counter; go to SEND.
  - start=1 with sel=111: err=1 for the next cycle; stay in IDLE; no data transferred.
- SEND:
  - out_valid=1; out_data = shift[OUT_W-1:0]; out_last = (cnt == len-1).
  - Handshake when out_valid & out_ready:
    - Shift right by OUT_W; cnt++.
    - If out_last, go to DONE.
  - No handshake: out_data, out_last and the shift register hold stable. out_valid never drops once raised until the last beat is accepted.
- DONE: done=1 for exactly one cycle, out_valid=0, then IDLE. busy=1 in SEND and DONE.
- Latency:
  - start edge → out_valid=1 on the next cycle.
  - Back-to-back streaming at full rate when out_ready is held high.
  - Total for a 64-byte register at OUT_W=8 with ready=1: 1 + 64 + 1 cycles from start to return to IDLE.
- Snapshot semantics: register file writes after the start cycle do not affect an in-progress transfer.
- start while busy: ignored; no queuing; no err.
- Byte order: beat k carries bits [k*OUT_W +: OUT_W] of the source register (little-endian, matching ED25519 encoding).
- Counter width: $clog2(512/OUT_W) bits; it never wraps because the transition to DONE happens at len-1.
- Reset mid-transfer: immediate abort to the reset state; no done pulse; the remaining beats are discarded.
- out_ready asserted while out_valid=0: no effect.

Test Plan:
- Reset, then start with sel=000 and reg_a1 = bytes 0x00..0x3F ascending (byte i = i), out_ready=1, OUT_W=8 → 64 beats 0x00,0x01,…,0x3F on consecutive cycles; out_last only on 0x3F; done pulse on the following cycle; busy falls after it.
- sel=010 with reg_a3[255:0] = {32{8'hA5}} ^ index pattern → exactly 32 beats; out_last on beat 31; no beats taken from the upper zero-extended half.
- Backpressure: same A1 transfer with out_ready toggled 1,0,0,1,… → out_data and out_last held stable while ready=0; full byte sequence intact; no duplicated or dropped bytes.
- Snapshot and busy handling: start sel=101, then overwrite reg_c1 on cycle 3 and pulse start with sel=110 mid-transfer → output equals the original C1 value; the second start is ignored; one done pulse only.
- Invalid select: start with sel=111 → err=1 for exactly one cycle; out_valid and busy stay 0; a following start with sel=100 works normally (32 beats).
- Async reset asserted at beat 20 of a B1 transfer → out_valid, busy and out_last drop to 0 immediately; no done pulse; after release a new start with sel=011 begins at beat 0.
